mouse_select_ctrl: RTL and testbench

- Sequences the player's two-click "pick source block, pick destination block" interaction, using the mouse interface's click pulses and block coordinates.
- Emits one move request per completed selection to the game-logic block through a req/ack/nack handshake.
- Cancels the selection on right click, on loss of turn, or on timeout.
- Applies a click hold-off after each accepted move.
- Sits between the mouse interface and the game-state controller, one instance per board.

---
 rtl/mouse_select_ctrl_pkg.sv | 11 +
 rtl/mouse_select_ctrl_if.sv | 27 ++
 rtl/mouse_select_ctrl_select_timer.sv | 17 +
 rtl/mouse_select_ctrl.sv | 81 ++++++++
 tb/tb_mouse_select_ctrl.sv | 120 ++++++++++++
 5 files changed

// File: rtl/mouse_select_ctrl_pkg.sv
// mouse_select_ctrl_pkg: state encoding and block coordinate widths shared by the selection controller.
package mouse_select_ctrl_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE     = 2'd0;
  localparam state_t SRC_SEL  = 2'd1;
  localparam state_t WAIT_ACK = 2'd2;
  localparam state_t HOLDOFF  = 2'd3;
  localparam int BLK_X_W      = 5;
  localparam int BLK_Y_W      = 3;
  localparam int HAND_ROW_MIN = 6;
endpackage

// File: rtl/mouse_select_ctrl_if.sv
// mouse_select_ctrl_if: mouse clicks/coordinates, turn flag and move handshake seen by the selection controller.
interface mouse_select_ctrl_if;
  import mouse_select_ctrl_pkg::*;
  logic               l_click;
  logic               r_click;
  logic               mouse_inblock;
  logic [BLK_X_W-1:0] mouse_block_x;
  logic [BLK_Y_W-1:0] mouse_block_y;
  logic               my_turn;
  logic               move_ack;
  logic               move_nack;
  logic               sel_valid;
  logic [BLK_X_W-1:0] sel_x;
  logic [BLK_Y_W-1:0] sel_y;
  logic               move_req;
  logic [BLK_X_W-1:0] move_dst_x;
  logic [BLK_Y_W-1:0] move_dst_y;
  logic               busy;
  modport master (
    output l_click, r_click, mouse_inblock, mouse_block_x, mouse_block_y, my_turn, move_ack, move_nack,
    input  sel_valid, sel_x, sel_y, move_req, move_dst_x, move_dst_y, busy
  );
  modport slave (
    input  l_click, r_click, mouse_inblock, mouse_block_x, mouse_block_y, my_turn, move_ack, move_nack,
    output sel_valid, sel_x, sel_y, move_req, move_dst_x, move_dst_y, busy
  );
endinterface

// File: rtl/mouse_select_ctrl_select_timer.sv
// select_timer: saturating cycle counter with clear/enable and a terminal-count compare.
module select_timer #(
  parameter int CNT_W = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_tc,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (!rst || i_clr) r_cnt <= '0;
    else if (i_en && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign o_done = r_cnt >= i_tc;
endmodule

// File: rtl/mouse_select_ctrl.sv
// mouse_select_ctrl: two-click source/destination selection with move handshake and hold-off.
// Define MOUSE_SELECT_TIMEOUT_EN to auto-cancel a pending source selection after TIMEOUT_CYC cycles.
module mouse_select_ctrl
  import mouse_select_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 500000000,
  parameter int HOLDOFF_CYC = 1000000,
  parameter int CNT_W       = 29
) (
  input logic                clk,
  input logic                rst,
  mouse_select_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] TO_TC   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLDOFF_CYC > 0 ? HOLDOFF_CYC - 1 : 0);
  state_t             r_state, w_next;
  logic               r_sel_valid, r_move_req, r_busy;
  logic [BLK_X_W-1:0] r_sel_x, r_dst_x;
  logic [BLK_Y_W-1:0] r_sel_y, r_dst_y;
  logic               w_click, w_same, w_done, w_to;
  logic               w_sel_valid, w_move_req, w_busy, w_sel_ld, w_dst_ld;
  assign w_click = bus.l_click & bus.mouse_inblock;
  assign w_same  = bus.mouse_block_x == r_sel_x && bus.mouse_block_y == r_sel_y;
`ifdef MOUSE_SELECT_TIMEOUT_EN
  assign w_to = w_done;
`else
  assign w_to = 1'b0;
`endif
  // One counter serves both timeout and hold-off; it restarts on every state change.
  select_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_next != r_state),
    .i_en   (r_state == SRC_SEL || r_state == HOLDOFF),
    .i_tc   (r_state == HOLDOFF ? HOLD_TC : TO_TC),
    .o_done (w_done)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      r_state     <= IDLE;
      r_sel_valid <= 1'b0;
      r_move_req  <= 1'b0;
      r_busy      <= 1'b0;
      r_sel_x     <= '0;
      r_sel_y     <= '0;
      r_dst_x     <= '0;
      r_dst_y     <= '0;
    end else begin
      r_state     <= w_next;
      r_sel_valid <= w_sel_valid;
      r_move_req  <= w_move_req;
      r_busy      <= w_busy;
      if (w_sel_ld) {r_sel_x, r_sel_y} <= {bus.mouse_block_x, bus.mouse_block_y};
      if (w_dst_ld) {r_dst_x, r_dst_y} <= {bus.mouse_block_x, bus.mouse_block_y};
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_click && bus.my_turn ? SRC_SEL : IDLE;
      SRC_SEL:  w_next = !bus.my_turn || bus.r_click ? IDLE :
                         w_click ? (w_same ? IDLE : WAIT_ACK) :
                         w_to ? IDLE : SRC_SEL;
      WAIT_ACK: w_next = bus.move_ack ? HOLDOFF : bus.move_nack ? SRC_SEL : WAIT_ACK;
      default:  w_next = w_done ? IDLE : HOLDOFF;
    endcase
  end
  always_comb begin
    w_sel_valid = w_next == SRC_SEL || w_next == WAIT_ACK;
    w_move_req  = w_next == WAIT_ACK;
    w_busy      = w_next == WAIT_ACK || w_next == HOLDOFF;
    w_sel_ld    = r_state == IDLE && w_next == SRC_SEL;
    w_dst_ld    = r_state == SRC_SEL && w_next == WAIT_ACK;
  end
  assign bus.sel_valid  = r_sel_valid;
  assign bus.sel_x      = r_sel_x;
  assign bus.sel_y      = r_sel_y;
  assign bus.move_req   = r_move_req;
  assign bus.move_dst_x = r_dst_x;
  assign bus.move_dst_y = r_dst_y;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_mouse_select_ctrl.sv
// tb_mouse_select_ctrl: directed stimulus with a scoreboard queue of expected output snapshots.
module tb_mouse_select_ctrl;
`ifdef MOUSE_SELECT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef struct {
    int          due;
    logic [18:0] exp;
    string       nm;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0, n_chk = 0, n_pass = 0;
  item_t q[$];
  logic [18:0] act;
  always #5 clk = ~clk;
  mouse_select_ctrl_if bus ();
  mouse_select_ctrl #(.TIMEOUT_CYC(50), .HOLDOFF_CYC(4), .CNT_W(29)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  assign act = {bus.sel_valid, bus.sel_x, bus.sel_y, bus.move_req, bus.move_dst_x, bus.move_dst_y, bus.busy};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    while (q.size() > 0 && q[0].due <= cyc) begin
      item_t it;
      it = q.pop_front();
      n_chk++;
      if (it.due == cyc && act === it.exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (due cycle %0d, seen %0d)", it.nm, act, it.exp, it.due, cyc);
    end
  function automatic logic [18:0] e(input logic sv, input logic [4:0] sx, input logic [2:0] sy,
                                    input logic mr, input logic [4:0] dx, input logic [2:0] dy, input logic bz);
    return {sv, sx, sy, mr, dx, dy, bz};
  endfunction
  task automatic st(input logic rs, l, r, inb, input logic [4:0] x, input logic [2:0] y,
                    input logic turn, ack, nack, input logic [18:0] exp, input string nm);
    @(negedge clk);
    rst = rs;
    bus.l_click = l;
    bus.r_click = r;
    bus.mouse_inblock = inb;
    bus.mouse_block_x = x;
    bus.mouse_block_y = y;
    bus.my_turn = turn;
    bus.move_ack = ack;
    bus.move_nack = nack;
    q.push_back('{due: cyc + 1, exp: exp, nm: nm});
  endtask
  task automatic idl(input logic [18:0] exp, input string nm);
    st(1, 0, 0, 1, 0, 0, 1, 0, 0, exp, nm);
  endtask
  task automatic lc(input logic [4:0] x, input logic [2:0] y, input logic [18:0] exp, input string nm);
    st(1, 1, 0, 1, x, y, 1, 0, 0, exp, nm);
  endtask
  initial begin
    bus.l_click = 0; bus.r_click = 0; bus.mouse_inblock = 0; bus.mouse_block_x = 0;
    bus.mouse_block_y = 0; bus.my_turn = 0; bus.move_ack = 0; bus.move_nack = 0;
    repeat (3) st(0, 1, 0, 1, 3, 2, 1, 0, 0, '0, "rst_hold");
    repeat (2) idl('0, "rst_release");
    lc(3, 2, e(1, 3, 2, 0, 0, 0, 0), "sel_src");
    idl(e(1, 3, 2, 0, 0, 0, 0), "sel_hold");
    lc(7, 6, e(1, 3, 2, 1, 7, 6, 1), "req");
    for (int i = 0; i < 10; i++)
      if (i == 5) lc(9, 1, e(1, 3, 2, 1, 7, 6, 1), "req_click_ignored");
      else idl(e(1, 3, 2, 1, 7, 6, 1), "req_hold");
    st(1, 0, 0, 1, 0, 0, 1, 1, 0, e(0, 3, 2, 0, 7, 6, 1), "ack");
    repeat (3) lc(3, 2, e(0, 3, 2, 0, 7, 6, 1), "holdoff");
    lc(3, 2, e(0, 3, 2, 0, 7, 6, 0), "holdoff_end");
    idl(e(0, 3, 2, 0, 7, 6, 0), "idle_after");
    lc(3, 2, e(1, 3, 2, 0, 7, 6, 0), "resel");
    lc(3, 2, e(0, 3, 2, 0, 7, 6, 0), "deselect");
    lc(3, 2, e(1, 3, 2, 0, 7, 6, 0), "resel2");
    st(1, 1, 1, 1, 5, 1, 1, 0, 0, e(0, 3, 2, 0, 7, 6, 0), "rl_cancel");
    lc(4, 4, e(1, 4, 4, 0, 7, 6, 0), "resel3");
    st(1, 0, 0, 1, 0, 0, 0, 0, 0, e(0, 4, 4, 0, 7, 6, 0), "turn_cancel");
    st(1, 1, 0, 1, 2, 2, 0, 0, 0, e(0, 4, 4, 0, 7, 6, 0), "idle_noturn");
    st(1, 1, 0, 0, 6, 1, 1, 0, 0, e(0, 4, 4, 0, 7, 6, 0), "idle_outblk");
    lc(1, 0, e(1, 1, 0, 0, 7, 6, 0), "nack_src");
    lc(2, 0, e(1, 1, 0, 1, 2, 0, 1), "nack_req");
    st(1, 0, 0, 1, 0, 0, 1, 0, 1, e(1, 1, 0, 0, 2, 0, 0), "nack");
    lc(4, 3, e(1, 1, 0, 1, 4, 3, 1), "req2");
    st(1, 0, 0, 1, 0, 0, 0, 0, 0, e(1, 1, 0, 1, 4, 3, 1), "turn_in_wait");
    st(1, 0, 0, 1, 0, 0, 1, 1, 1, e(0, 1, 0, 0, 4, 3, 1), "ack_nack");
    repeat (3) idl(e(0, 1, 0, 0, 4, 3, 1), "holdoff2");
    idl(e(0, 1, 0, 0, 4, 3, 0), "holdoff2_end");
    lc(8, 2, e(1, 8, 2, 0, 4, 3, 0), "to_sel");
    st(1, 1, 0, 0, 9, 3, 1, 0, 0, e(1, 8, 2, 0, 4, 3, 0), "src_outblk");
    for (int i = 2; i <= 200; i++)
      if (i == 100) st(1, 1, 0, 0, 9, 3, 1, 0, 0, e(TO_EN ? 1'b0 : 1'b1, 8, 2, 0, 4, 3, 0), "to_outblk");
      else idl(e(TO_EN ? (i < 50) : 1'b1, 8, 2, 0, 4, 3, 0), "timeout");
    st(1, 0, 1, 1, 0, 0, 1, 0, 0, e(0, 8, 2, 0, 4, 3, 0), "r_cancel");
    lc(10, 5, e(1, 10, 5, 0, 4, 3, 0), "mid_sel");
    lc(11, 6, e(1, 10, 5, 1, 11, 6, 1), "mid_req");
    st(0, 0, 0, 1, 0, 0, 1, 0, 0, '0, "rst_mid");
    idl('0, "after_rst");
    @(negedge clk);
    n_chk++;
    if (bus.move_req === 1'b0 && bus.sel_valid === 1'b0 && bus.busy === 1'b0) n_pass++;
    else $display("FAIL post_rst_direct: move_req=%b sel_valid=%b busy=%b", bus.move_req, bus.sel_valid, bus.busy);
    n_chk++;
    if (act === 19'd0) n_pass++;
    else $display("FAIL post_rst_outputs: got %b", act);
    repeat (3) @(negedge clk);
    while (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      n_chk++;
      $display("FAIL %s: never checked, expected %b", it.nm, it.exp);
    end
    if (n_chk < 12) $display("FAIL too few checks: %0d", n_chk);
    if (n_pass == n_chk) $display("PASS");
    else $display("FAIL %0d checks failed", n_chk - n_pass);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
